// File: rtl/fwd_mac_seq_pkg.sv
// ---------------------------------------------------------------------------
// fwd_mac_seq_pkg
// Shared definitions for the forward-pass MAC sequencer and its neighbours
// (pass state machine, operand feeders).
//   - State encodings of the sequencer FSM
//   - Datapath widths: ACC_W (accumulator), OP_W (operands), LEN_W (term count)
//   - operand_t: one activation/weight pair
//   - len_to_count(): maps the 4-bit length field to a term count (0 -> 16)
// ---------------------------------------------------------------------------
package fwd_mac_seq_pkg;

  localparam int ACC_W  = 20;
  localparam int OP_W   = 8;
  localparam int LEN_W  = 4;
  // One extra bit so that a count of 16 is representable.
  localparam int CNT_W  = LEN_W + 1;
  localparam int PROD_W = 2 * OP_W;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  typedef struct packed {
    logic [OP_W-1:0] x;  // signed activation, two's complement
    logic [OP_W-1:0] w;  // signed weight, two's complement
  } operand_t;

  // A length field of zero means the full 2**LEN_W terms.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [LEN_W-1:0] len);
    if (len == '0) begin
      return CNT_W'(1 << LEN_W);
    end
    return CNT_W'(len);
  endfunction

endpackage

// File: rtl/fwd_mac_seq_if.sv
// ---------------------------------------------------------------------------
// fwd_mac_seq_if
// Operand stream between a feeder and the MAC sequencer.
//   x_i, w_i  : signed operand pair          (feeder -> sequencer)
//   valid_i   : operand pair valid           (feeder -> sequencer)
//   ready_o   : sequencer accepts this cycle (sequencer -> feeder)
//   idx_o     : index of next expected term  (sequencer -> feeder)
// A pair moves when valid_i and ready_o are both high on an enabled edge.
// ---------------------------------------------------------------------------
interface fwd_mac_seq_if;
  import fwd_mac_seq_pkg::*;

  logic [OP_W-1:0]  x_i;
  logic [OP_W-1:0]  w_i;
  logic             valid_i;
  logic             ready_o;
  logic [LEN_W-1:0] idx_o;

  // Feeder side
  modport master (
    output x_i,
    output w_i,
    output valid_i,
    input  ready_o,
    input  idx_o
  );

  // Sequencer side
  modport slave (
    input  x_i,
    input  w_i,
    input  valid_i,
    output ready_o,
    output idx_o
  );

endinterface

// File: rtl/fwd_mac_seq_mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
// Signed multiply-accumulate datapath: full OP_W x OP_W signed product,
// sign-extended to ACC_W and added into the accumulator register.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-low reset, clears the accumulator
//   clr_i  : synchronous clear (start of a pass)
//   en_i   : accumulate the current operand pair
//   op_i   : operand pair
//   acc_o  : accumulator value (registered)
// clr_i has priority over en_i. No saturation: the widest possible pass
// (16 x (-128 * -128)) still fits in ACC_W signed bits.
// ---------------------------------------------------------------------------
module mac_unit
  import fwd_mac_seq_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  operand_t                op_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_reg;

  assign prod = $signed(op_i.x) * $signed(op_i.w);
  assign term = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_reg <= '0;
    end else if (clr_i) begin
      acc_reg <= '0;
    end else if (en_i) begin
      acc_reg <= acc_reg + term;
    end
  end

  assign acc_o = acc_reg;

endmodule

// File: rtl/fwd_mac_seq.sv
// ---------------------------------------------------------------------------
// fwd_mac_seq
// Forward-pass MAC sequencer. On a pass request it latches a term count,
// clears the accumulator, then accepts that many operand pairs over a
// valid/ready stream, accumulating their signed products. When the last
// term is in, it raises end_check_o until the request is withdrawn.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-low reset (wins over en_i)
//   en_i         : global enable; all registers hold when low
//   f0_pass_i    : pass request level; dropping it aborts LOAD/RUN
//   len_i        : term count, 0 encodes 16 (sampled in LOAD only)
//   op           : operand stream (x_i, w_i, valid_i, ready_o, idx_o)
//   acc_o        : signed accumulated dot product
//   busy_o       : high in LOAD or RUN
//   end_check_o  : high in DONE
//   state_o      : current FSM state
// ---------------------------------------------------------------------------
module fwd_mac_seq
  import fwd_mac_seq_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    f0_pass_i,
  input  logic [LEN_W-1:0]        len_i,
  fwd_mac_seq_if.slave            op,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    busy_o,
  output logic                    end_check_o,
  output logic [1:0]              state_o
);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [LEN_W-1:0] idx_reg;
  logic [CNT_W-1:0] count_reg;

  logic     in_load;
  logic     in_run;
  logic     xfer;
  logic     last_term;
  logic     load_go;
  operand_t pair;

  assign in_load = (state_reg == ST_LOAD);
  assign in_run  = (state_reg == ST_RUN);

  // A falling pass request aborts on the same edge, so a pair offered on
  // that edge is not taken.
  assign xfer      = in_run & op.valid_i & en_i & f0_pass_i;
  assign last_term = ({1'b0, idx_reg} == (count_reg - CNT_W'(1)));
  assign load_go   = in_load & en_i & f0_pass_i;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (f0_pass_i) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_next = f0_pass_i ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!f0_pass_i) begin
          state_next = ST_IDLE;
        end else if (op.valid_i && last_term) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!f0_pass_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      count_reg <= len_to_count('0);
    end else if (en_i) begin
      state_reg <= state_next;
      if (load_go) begin
        count_reg <= len_to_count(len_i);
        idx_reg   <= '0;
      end else if (xfer) begin
        // Wraps to 0 after the 16th term of a full-length pass.
        idx_reg <= idx_reg + LEN_W'(1);
      end
    end
  end

  assign pair.x = op.x_i;
  assign pair.w = op.w_i;

  mac_unit u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (load_go),
    .en_i  (xfer),
    .op_i  (pair),
    .acc_o (acc_o)
  );

  assign op.ready_o  = in_run;
  assign op.idx_o    = idx_reg;
  assign busy_o      = in_load | in_run;
  assign end_check_o = (state_reg == ST_DONE);
  assign state_o     = state_reg;

endmodule

// File: tb/tb_fwd_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_fwd_mac_seq
// Directed and randomized passes through fwd_mac_seq. Expected accumulator
// values are running sums of x*w over the pairs the bench actually handed
// over; expected states follow from how many terms have been sent.
// ---------------------------------------------------------------------------
module tb_fwd_mac_seq;
  import fwd_mac_seq_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    f0;
  logic [LEN_W-1:0]        len;
  logic signed [ACC_W-1:0] acc;
  logic                    busy;
  logic                    endc;
  logic [1:0]              state;

  fwd_mac_seq_if bus ();

  fwd_mac_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .f0_pass_i   (f0),
    .len_i       (len),
    .op          (bus),
    .acc_o       (acc),
    .busy_o      (busy),
    .end_check_o (endc),
    .state_o     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: running sum of products, terms sent, terms expected.
  int exp_acc;
  int exp_idx;
  int exp_count;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"}, int'(state), int'(ST_IDLE));
    chk({tag, ".acc"}, int'(acc), 0);
    chk({tag, ".idx"}, int'(bus.idx_o), 0);
    chk({tag, ".ready"}, int'(bus.ready_o), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".end"}, int'(endc), 0);
  endtask

  task automatic start_pass(input int l);
    logic [LEN_W-1:0] lv;
    lv = l[LEN_W-1:0];
    bus.valid_i = 1'b0;
    len = lv;
    f0  = 1'b1;
    tick();
    chk("load.state", int'(state), int'(ST_LOAD));
    chk("load.busy", int'(busy), 1);
    chk("load.ready", int'(bus.ready_o), 0);
    tick();
    chk("run.state", int'(state), int'(ST_RUN));
    chk("run.acc_clr", int'(acc), 0);
    chk("run.idx_clr", int'(bus.idx_o), 0);
    chk("run.ready", int'(bus.ready_o), 1);
    // Length must be ignored from here on.
    len = LEN_W'($urandom);
    exp_acc   = 0;
    exp_idx   = 0;
    exp_count = (l % 16 == 0) ? 16 : (l % 16);
  endtask

  task automatic send(input int xv, input int wv);
    bus.x_i = xv[OP_W-1:0];
    bus.w_i = wv[OP_W-1:0];
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    exp_acc += xv * wv;
    exp_idx++;
    chk("xfer.acc", int'(acc), exp_acc);
    chk("xfer.idx", int'(bus.idx_o), exp_idx % 16);
    if (exp_idx == exp_count) begin
      chk("xfer.state_done", int'(state), int'(ST_DONE));
      chk("xfer.end", int'(endc), 1);
      chk("xfer.busy", int'(busy), 0);
    end else begin
      chk("xfer.state_run", int'(state), int'(ST_RUN));
      chk("xfer.end_low", int'(endc), 0);
    end
  endtask

  // Idle cycles in RUN: either valid low, or valid high with enable low.
  task automatic gap(input int n, input bit en_low);
    for (int i = 0; i < n; i++) begin
      bus.x_i = OP_W'($urandom);
      bus.w_i = OP_W'($urandom);
      bus.valid_i = en_low;
      en = ~en_low;
      tick();
      chk("gap.state", int'(state), int'(ST_RUN));
      chk("gap.acc", int'(acc), exp_acc);
      chk("gap.idx", int'(bus.idx_o), exp_idx % 16);
    end
    en = 1'b1;
    bus.valid_i = 1'b0;
  endtask

  task automatic finish_done(input int hold);
    for (int i = 0; i < hold; i++) begin
      f0 = 1'b1;
      bus.valid_i = 1'($urandom);
      bus.x_i = OP_W'($urandom);
      bus.w_i = OP_W'($urandom);
      tick();
      chk("done.state", int'(state), int'(ST_DONE));
      chk("done.end", int'(endc), 1);
      chk("done.acc_hold", int'(acc), exp_acc);
      chk("done.ready", int'(bus.ready_o), 0);
    end
    bus.valid_i = 1'b0;
    f0 = 1'b0;
    tick();
    chk("exit.state", int'(state), int'(ST_IDLE));
    chk("exit.end", int'(endc), 0);
    chk("exit.acc", int'(acc), exp_acc);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    f0  = 1'b0;
    len = '0;
    bus.x_i = '0;
    bus.w_i = '0;
    bus.valid_i = 1'b0;

    // Reset state
    tick();
    chk_reset_vals("reset");
    rst = 1'b1;

    // Enable low in IDLE: request must not be acted on
    en = 1'b0;
    f0 = 1'b1;
    tick();
    tick();
    chk("en_low_idle.state", int'(state), int'(ST_IDLE));
    en = 1'b1;
    f0 = 1'b0;
    tick();

    // Basic pass: (2,3) (-4,5) (7,-1) -> -21
    start_pass(3);
    send(2, 3);
    send(-4, 5);
    send(7, -1);
    chk("basic.acc", int'(acc), -21);
    chk("basic.idx", int'(bus.idx_o), 3);
    finish_done(3);

    // Full-length pass, extreme operands, no wrap
    start_pass(0);
    for (int i = 0; i < 16; i++) begin
      send(-128, -128);
    end
    chk("full.acc", int'(acc), 262144);
    finish_done(1);

    // Gapped valid 1,0,0,1,1 with an enable-low cycle before the last pair
    start_pass(3);
    send(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    gap(2, 1'b0);
    send(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    gap(1, 1'b1);
    send(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    finish_done(0);

    // Abort after 2 of 5 transfers
    start_pass(5);
    send(13, -9);
    send(-100, 77);
    f0 = 1'b0;
    tick();
    chk("abort.state", int'(state), int'(ST_IDLE));
    chk("abort.end", int'(endc), 0);
    chk("abort.acc_partial", int'(acc), exp_acc);
    chk("abort.busy", int'(busy), 0);
    start_pass(5);
    for (int i = 0; i < 5; i++) begin
      send(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    end
    finish_done(1);

    // Reset mid-RUN, asserted together with enable low
    start_pass(4);
    send(50, 60);
    send(-7, 11);
    rst = 1'b0;
    en  = 1'b0;
    f0  = 1'b0;
    bus.valid_i = 1'b1;
    tick();
    chk_reset_vals("rst_mid");
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_after.state", int'(state), int'(ST_IDLE));
      chk("rst_after.end", int'(endc), 0);
      chk("rst_after.acc", int'(acc), 0);
    end
    bus.valid_i = 1'b0;

    // Randomized passes: random length, gaps, enable drops and DONE holds
    for (int p = 0; p < 8; p++) begin
      start_pass(int'($urandom_range(15)));
      for (int t = 0; t < exp_count; t++) begin
        if (t != 0) begin
          gap(int'($urandom_range(2)), 1'($urandom));
        end
        send(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
      end
      finish_done(int'($urandom_range(2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_mac_seq.md
FWD_MAC_SEQ -- requirements
Module: fwd_mac_seq

Interface
REQ-001 The block SHALL expose these ports, listed as name, direction, width, meaning:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  synchronous active-low reset.
- en_i  in  1  global enable; when low, all registers hold.
- f0_pass_i  in  1  forward-pass request level from the pass state machine.
- len_i  in  4  term count; 0 encodes 16.
- x_i  in  8  signed activation operand.
- w_i  in  8  signed weight operand.
- valid_i  in  1  operand pair valid.
- ready_o  out  1  block accepts an operand pair this cycle.
- idx_o  out  4  index of the next term expected.
- acc_o  out  20  signed accumulated dot product.
- busy_o  out  1  high in the LOAD or RUN state.
- end_check_o  out  1  pass complete; feeds the state machine's end_check input.
- state_o  out  2  current state, for debug.

Function
REQ-002 The block SHALL implement four states with these encodings: IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11.
REQ-003 The block SHALL evaluate state transitions and register updates only on clock edges where en_i=1 and rst_i=1.
REQ-004 IDLE: when f0_pass_i=1, the block SHALL move to LOAD. Otherwise it SHALL stay in IDLE.
REQ-005 LOAD: the block SHALL perform the following, then move to RUN on the next cycle. This is a one-cycle state.
- Latch len_i into the internal term count, mapping 0 to 16.
- Clear acc to 0.
- Clear idx to 0.
REQ-006 The block SHALL drive ready_o=1 only in RUN. A transfer occurs when valid_i, ready_o and en_i are all 1.
REQ-007 On each transfer, the block SHALL perform acc <= acc + sext20(x_i*w_i). The product SHALL be a full signed 16-bit product.
REQ-008 On each transfer, the block SHALL increment idx by 1.
REQ-009 On the transfer where idx equals count-1, the block SHALL move to DONE, and acc_o SHALL include that final term.
REQ-010 The block SHALL NOT overflow acc_o: 16 terms of magnitude 16384 at most sum to |2^18|, which fits in 20 signed bits. No saturation logic SHALL be present.
REQ-011 DONE: the block SHALL drive end_check_o=1 and hold acc_o. It SHALL return to IDLE when f0_pass_i=0.
REQ-012 If f0_pass_i falls while in LOAD or RUN, the block SHALL abort to IDLE on that edge and SHALL NOT assert end_check_o. acc_o SHALL retain its partial value.
REQ-013 In RUN, the block SHALL ignore valid_i=1 whenever en_i=0.
REQ-014 The block SHALL drive busy_o=1 in the LOAD and RUN states.
REQ-015 The block SHALL drive idx_o and state_o directly from registers.
REQ-016 Latched len SHALL be immune to len_i changes after LOAD.
REQ-017 If f0_pass_i stays high after DONE returns to IDLE via a low pulse, the block SHALL start a new pass.

Reset
REQ-018 When rst_i=0 at a clock edge, the block SHALL set the following, regardless of en_i:
- state to IDLE
- acc_o to 0
- idx_o to 0
- latched count to 16
- ready_o, busy_o and end_check_o to 0
REQ-019 A reset in any state, including mid-RUN, SHALL take effect on the next edge and SHALL discard any partial accumulation.

Structure
REQ-020 A shared package SHALL hold the following, for reuse by the pass state machine and its neighbours:
- the state encodings
- ACC_W=20
- OP_W=8
- LEN_W=4
REQ-021 The datapath SHALL be a single sub-module, mac_unit, containing the signed multiplier, the sign-extension and the accumulator register with clear and enable. The FSM, counter and handshake SHALL live in fwd_mac_seq.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Basic pass: len=3, pairs (2,3), (-4,5), (7,-1) with valid held high -> acc_o=-21, end_check_o=1 three cycles after entering RUN, idx_o=3.
- len=0 with 16 pairs of (-128,-128) -> acc_o=262144 with no wrap, end_check_o=1 after the 16th transfer.
- Gapped valid_i (pattern 1,0,0,1,1), plus an en_i=0 cycle mid-RUN -> only handshaked pairs counted, and the state holds during en_i=0.
- Abort: f0_pass_i falls after 2 of 5 transfers -> IDLE next cycle, end_check_o stays 0, and the next pass restarts at idx 0 with acc 0.
- Reset mid-RUN with rst_i=0 for one cycle -> all outputs at reset values on the next edge, and DONE is not reached.
- DONE exit: f0_pass_i held high -> end_check_o stays 1 and acc_o is stable; f0_pass_i dropped -> IDLE the next cycle and end_check_o=0.
